// File: rtl/vending_pkg.sv
// Shared types and constants for the coin vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    // Coin values expressed in 5-kurus units.
    localparam int unsigned COIN5_UNITS    = 1;
    localparam int unsigned COIN10_UNITS   = 2;
    localparam int unsigned COIN25_UNITS   = 5;
    localparam int unsigned KURUS_PER_UNIT = 5;

endpackage

// File: rtl/vending_coin_decoder.sv
// Coin strobe decoder: a coin is valid only when exactly one strobe is high.
module vending_coin_decoder
    import vending_pkg::*;
#(
    parameter int VAL_W = 5
) (
    input  logic             i_five,
    input  logic             i_ten,
    input  logic             i_twentyFive,
    output logic             coinValid,
    output logic [VAL_W-1:0] coinValue
);

    always_comb begin
        coinValid = 1'b0;
        coinValue = '0;
        case ({i_twentyFive, i_ten, i_five})
            3'b001: begin
                coinValid = 1'b1;
                coinValue = VAL_W'(COIN5_UNITS);
            end
            3'b010: begin
                coinValid = 1'b1;
                coinValue = VAL_W'(COIN10_UNITS);
            end
            3'b100: begin
                coinValid = 1'b1;
                coinValue = VAL_W'(COIN25_UNITS);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vending_controller.sv
// Two-product coin vending FSM with credit accumulator and unit-by-unit change.
// Optional escrow auto-refund enabled by defining VENDING_ESCROW_TIMEOUT_EN.
module vending_controller
    import vending_pkg::*;
#(
    parameter int CREDIT_W       = 4,
    parameter int MAX_CREDIT     = 15,
    parameter int PRICE0         = 6,
    parameter int PRICE1         = 9,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                fiveKurus,
    input  logic                tenKurus,
    input  logic                twentyFiveKurus,
    input  logic                productSel,
    input  logic                cancel,
    output logic                theProduct,
    output logic                productId,
    output logic                changeOut,
    output logic                coinReject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    // One spare bit so credit+coin can never wrap before the limit check.
    localparam int SUM_W = CREDIT_W + 1;
    localparam logic [SUM_W-1:0] L_MAX    = SUM_W'(MAX_CREDIT);
    localparam logic [SUM_W-1:0] L_PRICE0 = SUM_W'(PRICE0);
    localparam logic [SUM_W-1:0] L_PRICE1 = SUM_W'(PRICE1);

    state_t              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic                r_productId, w_productId_nxt;
    logic                r_coinReject, w_coinReject_nxt;
    logic                w_coinAccept;
    logic                w_coinValid;
    logic [SUM_W-1:0]    w_coinValue;
    logic [SUM_W-1:0]    w_creditExt;
    logic [SUM_W-1:0]    w_sum;
    logic [SUM_W-1:0]    w_price;
    logic                w_timeout;
    logic                w_refund;

    vending_coin_decoder #(.VAL_W(SUM_W)) u_dec (
        .i_five       (fiveKurus),
        .i_ten        (tenKurus),
        .i_twentyFive (twentyFiveKurus),
        .coinValid    (w_coinValid),
        .coinValue    (w_coinValue)
    );

    assign w_creditExt = {1'b0, r_credit};
    assign w_sum       = w_creditExt + w_coinValue;
    assign w_price     = productSel ? L_PRICE1 : L_PRICE0;
    assign w_refund    = (cancel && (r_credit != '0)) || w_timeout;

`ifdef VENDING_ESCROW_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] r_idle;

    assign w_timeout = (r_state == COLLECT) && (r_credit != '0) &&
                       (r_idle == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || (r_state != COLLECT) || w_coinAccept) begin
            r_idle <= '0;
        end else if (r_credit != '0) begin
            r_idle <= r_idle + TO_W'(1);
        end
    end
`else
    logic w_unused_timeout;
    assign w_timeout        = 1'b0;
    assign w_unused_timeout = w_coinAccept ^ (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= COLLECT;
            r_credit     <= '0;
            r_productId  <= 1'b0;
            r_coinReject <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_credit     <= w_credit_nxt;
            r_productId  <= w_productId_nxt;
            r_coinReject <= w_coinReject_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_credit_nxt     = r_credit;
        w_productId_nxt  = r_productId;
        w_coinReject_nxt = 1'b0;
        w_coinAccept     = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_refund) begin
                    w_state_nxt      = CHANGE;
                    w_coinReject_nxt = w_coinValid;
                end else if (w_creditExt >= w_price) begin
                    w_state_nxt      = VEND;
                    w_credit_nxt     = r_credit - w_price[CREDIT_W-1:0];
                    w_productId_nxt  = productSel;
                    w_coinReject_nxt = w_coinValid;
                end else if (w_coinValid) begin
                    if (w_sum <= L_MAX) begin
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                        w_coinAccept = 1'b1;
                    end else begin
                        w_coinReject_nxt = 1'b1;
                    end
                end
            end
            VEND: begin
                w_state_nxt      = (r_credit != '0) ? CHANGE : COLLECT;
                w_coinReject_nxt = w_coinValid;
            end
            CHANGE: begin
                w_coinReject_nxt = w_coinValid;
                if (r_credit <= CREDIT_W'(1)) begin
                    w_credit_nxt = '0;
                    w_state_nxt  = COLLECT;
                end else begin
                    w_credit_nxt = r_credit - CREDIT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = COLLECT;
                w_credit_nxt = '0;
            end
        endcase
    end

    assign theProduct = (r_state == VEND);
    assign productId  = (r_state == VEND) & r_productId;
    assign changeOut  = (r_state == CHANGE);
    assign busy       = (r_state != COLLECT);
    assign coinReject = r_coinReject;
    assign credit     = r_credit;

endmodule

// File: doc/vending_controller.md
Name: vending_controller

Overview:
- Parametrised successor to the single-price coin vending FSM.
- Accepts 5/10/25 kurus coins into a registered credit accumulator and supports two products with independent prices.
- Vends when credit covers the selected price, then returns change one 5-kurus unit per cycle; a cancel button refunds all credit.
- Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

Parameters:
- CREDIT_W, 4, width of credit register, in 5-kurus units.
- MAX_CREDIT, 15, maximum credit held, in units; must be <= 2**CREDIT_W-1.
- PRICE0, 6, price of product 0 in units (6 = 30 kurus); 1..MAX_CREDIT.
- PRICE1, 9, price of product 1 in units (9 = 45 kurus); 1..MAX_CREDIT.
- TIMEOUT_CYCLES, 1000, idle cycles before auto-refund (used only with the optional feature).

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- fiveKurus  input  1  5-kurus coin strobe, one cycle per coin.
- tenKurus  input  1  10-kurus coin strobe.
- twentyFiveKurus  input  1  25-kurus coin strobe.
- productSel  input  1  selected product: 0 or 1.
- cancel  input  1  refund request, level or pulse.
- theProduct  output  1  dispense pulse, exactly one cycle per vend.
- productId  output  1  product being dispensed; valid while theProduct=1.
- changeOut  output  1  one cycle high = return one 5-kurus unit.
- coinReject  output  1  one-cycle pulse: a valid coin was not accepted.
- credit  output  CREDIT_W  current registered credit, in units.
- busy  output  1  high in VEND and CHANGE states.

Behaviour:
- Reset is synchronous and active-high. On reset: state=COLLECT, credit=0, and all outputs 0 on the following cycle.
- Reset asserted in any state, including mid-CHANGE, discards credit with no refund.
- A coin is valid only when exactly one strobe is high. Any multi-strobe combination is ignored: no credit change, no reject.
- Coin values are five=1, ten=2, twentyFive=5 units.
- States: COLLECT, VEND, CHANGE. Outputs are Moore, decoded from registered state, except coinReject, which is registered and asserted the cycle after the offending coin.
- COLLECT priority order, per cycle:
  - (1) cancel=1 and credit>0 -> CHANGE.
  - (2) credit >= price(productSel) -> VEND; credit <= credit - price; productId latched from productSel. A coin arriving in this cycle is rejected.
  - (3) valid coin with credit+value <= MAX_CREDIT -> credit += value.
  - (4) valid coin with credit+value > MAX_CREDIT -> credit unchanged, coinReject.
- cancel with credit=0 is a no-op.
- VEND: theProduct=1 for one cycle. Next state is CHANGE if credit>0, else COLLECT.
- CHANGE: changeOut=1 every cycle; credit decrements by 1 per cycle. In the cycle credit==1, credit goes to 0 and the state goes to COLLECT. A refund of N units therefore yields exactly N consecutive changeOut cycles.
- Coins arriving in VEND or CHANGE are rejected. cancel is ignored in VEND and CHANGE.
- Latency: coin sampled at edge N, credit updated at N+1. If the price is now met, VEND is entered at N+2 and theProduct is high in cycle N+2.
- productSel may change freely in COLLECT; the comparison uses its current value each cycle.
- Credit arithmetic uses CREDIT_W+1 bits internally so the overflow check cannot wrap.

Optional Feature:
- Macro VENDING_ESCROW_TIMEOUT_EN.
- Defined: a counter clears on any accepted coin or on leaving COLLECT, and increments each COLLECT cycle with credit>0. On reaching TIMEOUT_CYCLES-1 the FSM enters CHANGE and refunds all credit, identical to cancel.
- Undefined: no counter, and credit is held indefinitely.

Decomposition:
- Package vending_pkg holds:
  - state enum (COLLECT, VEND, CHANGE);
  - coin value constants COIN5_UNITS=1, COIN10_UNITS=2, COIN25_UNITS=5;
  - the unit-to-kurus factor (5).
- Sub-module vending_coin_decoder: combinational one-hot check plus value lookup, outputs coinValid and coinValue.
- FSM and credit datapath stay in vending_controller.

Test Plan:
- Reset, sel=0, 25 then 5 -> credit 5, then 6; theProduct one cycle with productId=0; no changeOut; credit 0; busy high 1 cycle.
- sel=0, 25, 25 -> credit 10 -> VEND leaves 4 -> exactly 4 changeOut cycles -> COLLECT, credit 0.
- five+ten in the same cycle -> credit unchanged, coinReject=0. Then ten alone -> credit 2.
- Override PRICE1=15, sel=1: coins 25, 25, ten (credit 12), then 25 -> coinReject pulse, credit stays 12. Then five -> 13.
- Credit 3, cancel -> 3 changeOut cycles, theProduct never high. A coin during CHANGE -> coinReject, refund count unaffected.
- Reset asserted mid-CHANGE with credit 2 -> next cycle changeOut=0, credit=0, busy=0, state COLLECT.
- With the macro and TIMEOUT_CYCLES=20: five, then idle -> after 20 COLLECT cycles, 1 changeOut cycle.
